// File: rtl/uart_byte_tx.sv
// uart_byte_tx: byte-wide UART transmitter, 8N1 on rs232_tx from a 50 MHz mclk.
// Baud is set by a fixed divisor table: one tick every D+1 cycles, 16 ticks per bit.
// Optional even parity between D7 and STOP when UART_TX_PARITY_EN is defined (8E1).
// rst is asynchronous and active-high; it aborts any frame in progress.
module uart_byte_tx (
    input  logic       mclk,
    input  logic       rst,
    input  logic [3:0] baud_set,
    input  logic [7:0] data_byte,
    input  logic       send_en,
    output logic       rs232_tx,
    output logic       uart_state,
    output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
    } state_t;
`endif

    // Divisor table shared with the receiver; unused codes fall back to the slowest rate.
    function automatic logic [8:0] baud_div(input logic [3:0] sel);
        case (sel)
            4'd0:    baud_div = 9'd324;
            4'd1:    baud_div = 9'd162;
            4'd2:    baud_div = 9'd80;
            4'd3:    baud_div = 9'd53;
            4'd4:    baud_div = 9'd26;
            default: baud_div = 9'd324;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [8:0] div_cnt_q;
    logic [3:0] tick_cnt_q;
    logic [8:0] div_q;
    logic [7:0] data_q;
`ifdef UART_TX_PARITY_EN
    logic       parity_q;
`endif
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       accept;
    logic       tick;
    logic       bit_end;

    // A request is only honoured while idle; mid-frame requests are dropped.
    assign accept  = send_en && (state_q == S_IDLE);
    assign tick    = busy_q && (div_cnt_q == div_q);
    assign bit_end = tick && (tick_cnt_q == 4'd15);

    // Frame snapshot and baud counters; cleared on acceptance so each frame starts phase-aligned.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= 9'd0;
            tick_cnt_q <= 4'd0;
            div_q      <= 9'd0;
            data_q     <= 8'd0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else if (accept) begin
            div_cnt_q  <= 9'd0;
            tick_cnt_q <= 4'd0;
            div_q      <= baud_div(baud_set);
            data_q     <= data_byte;
`ifdef UART_TX_PARITY_EN
            parity_q   <= ^data_byte;
`endif
        end else if (busy_q) begin
            div_cnt_q <= tick ? 9'd0 : div_cnt_q + 9'd1;
            if (tick) begin
                tick_cnt_q <= tick_cnt_q + 4'd1;
            end
        end
    end

    // State register together with the registered line outputs.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: every non-idle state lasts exactly 16 ticks.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            S_IDLE: begin
                bit_idx_d = 3'd0;
                if (send_en) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the line changes on the same edge as the state.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_STOP) && bit_end;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_q[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign rs232_tx   = tx_q;
    assign uart_state = busy_q;
    assign tx_done    = done_q;

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Byte-wide UART transmitter; the transmit-side counterpart of the team's `uart_byte_rx` 16x-oversampling receiver, sharing its `baud_set` encoding and 50 MHz `mclk` divisor table. Accepts one byte per `send_en` request and serialises it LSB-first as 8N1 (optionally 8E1) on `rs232_tx`. Reports busy via `uart_state` and end-of-frame via a one-cycle `tx_done`. Sits between the byte source (FIFO or test logic) and the board TX pin.

## Interface
- No parameters. Divisor table is fixed; parity is selected by macro (see Configuration).
- `mclk` in 1: system clock, 50 MHz.
- `rst` in 1: **asynchronous, active-high reset**.
- `baud_set` in 4: baud select; sampled only when a request is accepted.
- `data_byte` in 8: byte to send; sampled only when a request is accepted.
- `send_en` in 1: transmit request; level-sampled each `mclk` edge.
- `rs232_tx` out 1: serial line, registered, idle high.
- `uart_state` out 1: 1 = frame in progress, 0 = idle.
- `tx_done` out 1: one-cycle pulse at frame end.

## Operation
- Divisor D from `baud_set`:
  - 0 → 324
  - 1 → 162
  - 2 → 80
  - 3 → 53
  - 4 → 26
  - 5–15 → 324
- Tick every D+1 `mclk` cycles; 16 ticks per bit, so each bit lasts 16·(D+1) cycles.
- Tick divider and bit counters run only while `uart_state`=1. They are cleared on acceptance, so every frame starts phase-aligned.
- FSM states: IDLE → START → DATA (bits 0..7) → [PARITY] → STOP → IDLE.
- **IDLE**:
  - `rs232_tx`=1.
  - Request accepted on any edge where `send_en`=1 and `uart_state`=0.
  - On accept: latch `data_byte`, D and parity; set `uart_state`=1; drive `rs232_tx`=0 (START).
- **START / DATA / PARITY / STOP**:
  - Each state holds the line for exactly 16·(D+1) cycles.
  - DATA drives `data_r[i]` for i=0..7, LSB first.
  - STOP drives 1.
- **Frame end** (at the end of STOP), on the same edge:
  - `uart_state`←0
  - `tx_done`←1 for exactly one cycle
  - `rs232_tx` stays 1
- **`send_en` while `uart_state`=1**: ignored. No queuing, no effect on the current frame. `data_byte` and `baud_set` changes mid-frame have no effect.
- **`send_en` held high continuously**: a new frame is accepted on the first edge after `uart_state` falls, giving back-to-back frames.
- **`rst` asserted mid-frame**: the frame is aborted immediately, without waiting for a clock.
  - `rs232_tx`=1, `uart_state`=0, `tx_done`=0.
  - All counters and the FSM return to 0/IDLE.
  - No partial resumption after release.

## Timing
- Reset values: `rs232_tx`=1, `uart_state`=0, `tx_done`=0, FSM=IDLE, counters=0, latched data=0.
- Let A be the accepting edge.
  - `uart_state` and a low `rs232_tx` are visible after A.
  - Bit k (k=0 for start) is driven from A+k·16(D+1) to A+(k+1)·16(D+1).
- Frame length F = 10·16·(D+1) cycles, or 11·16·(D+1) with parity.
  - `tx_done`=1 and `uart_state`=0 after edge A+F.
  - `tx_done` falls after A+F+1.
- Earliest next accept is edge A+F+1. The resulting idle gap between frames is 1 `mclk` cycle, which is acceptable beyond the full-length stop bit.
- Bit-length error vs. nominal baud is bounded by the divisor table; no fractional correction.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- **Defined**: even parity bit inserted between D7 and STOP.
  - Value is ^`data_r`: 1 when the byte has an odd number of ones.
  - Frame is 11 bits; F = 176·(D+1).
- **Undefined**: no parity state and no parity logic; 8N1, F = 160·(D+1).

## Test plan
- **Reset**: assert `rst` with no clock edge → `rs232_tx`=1, `uart_state`=0, `tx_done`=0 immediately.
- **Basic frame**: `baud_set`=4, `data_byte`=0x55, one-cycle `send_en`.
  - Line is 0,1,0,1,0,1,0,1,0,1, each bit 432 cycles.
  - `tx_done` pulses 4320 cycles after accept, for 1 cycle.
- **Ignored request**: `baud_set`=0, send 0xA3. At mid-frame, pulse `send_en` with `data_byte`=0xFF and `baud_set`=4.
  - Frame is unchanged: bits 1,1,0,0,0,1,0,1, 5200 cycles per bit.
  - No second frame follows.
- **Back-to-back**: `send_en` held high with 0x0F, then 0xF0 presented after the first accept.
  - Two frames; the second start bit begins 1 cycle after the first frame's `tx_done` edge.
  - Exactly two `tx_done` pulses if `send_en` drops during frame 2.
- **Reset mid-frame**: `baud_set`=2, send 0x00, assert `rst` at bit 4.
  - Line goes high at once and `uart_state`=0.
  - After release and a new request of 0x81, a full clean frame is sent.
- **Parity** (with `UART_TX_PARITY_EN`): `baud_set`=4.
  - Send 0x01 → parity bit 1.
  - Send 0x03 → parity bit 0.
  - F=4752 cycles; stop bit high.
